// File: rtl/serializer_tx_if.sv
// Parallel-in / serial-out bus between a word producer and serializer_tx.
// The master side supplies words; the slave side (serializer_tx) returns the
// serial stream together with its framing and status flags.
interface serializer_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             frame_end;
    logic             word_sent;
    logic             idle_frame;
    logic [7:0]       underrun_cnt;

    modport master (
        output din, din_valid,
        input  din_ready, dout, frame_end, word_sent, idle_frame, underrun_cnt
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dout, frame_end, word_sent, idle_frame, underrun_cnt
    );
endinterface

// File: rtl/serializer_tx.sv
// Free-running frame serializer. Every frame is WIDTH data slots, MSB first,
// followed by one guard slot driven low. A one-entry holding register lets a
// producer hand over the next word while the current one is being shifted.
// Frames with no user data carry IDLE_WORD and are counted as underruns.
module serializer_tx #(
    parameter int               WIDTH     = 8,
    parameter int               LOG_WIDTH = 3,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
    input  logic           clock_in,
    input  logic           reset_n,
    serializer_tx_if.slave bus
);

    typedef enum logic {
        SHIFT = 1'b0,
        GUARD = 1'b1
    } state_t;

    localparam int unsigned        LAST_DATA = WIDTH - 1;
    localparam logic [LOG_WIDTH:0] LAST_SLOT = LAST_DATA[LOG_WIDTH:0];

    state_t             state;
    state_t             state_next;
    logic [LOG_WIDTH:0] slot_cnt;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   hold_reg;
    logic               hold_full;
    logic               frame_user;    // current frame carries user data
    logic [7:0]         underrun_cnt;
    logic               load_edge;     // GUARD->SHIFT edge: next frame is loaded
    logic               accept;

    // Next-state decode and register-only output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        state_next       = state;
        load_edge        = 1'b0;
        bus.din_ready    = ~hold_full;
        bus.dout         = 1'b0;
        bus.frame_end    = 1'b0;
        bus.word_sent    = 1'b0;
        bus.idle_frame   = ~frame_user;
        bus.underrun_cnt = underrun_cnt;
        case (state)
            SHIFT: begin
                bus.dout = shift_reg[WIDTH-1];
                if (slot_cnt == LAST_SLOT) begin
                    state_next = GUARD;
                end
            end
            GUARD: begin
                state_next    = SHIFT;
                load_edge     = 1'b1;
                bus.frame_end = 1'b1;
                bus.word_sent = frame_user;
            end
        endcase
    end

    // A word is taken into the holding register only while it is empty.
    assign accept = bus.din_valid & ~hold_full;

    // State register.
    always_ff @(posedge clock_in) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (!reset_n) begin
            state <= SHIFT;
        end else begin
            state <= state_next;
        end
    end

    // Slot counter, shifter, hold flag and underrun counter. An idle frame
    // is counted when it finishes, so the frame begun by reset is included.
    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            slot_cnt     <= '0;
            shift_reg    <= IDLE_WORD;
            hold_full    <= 1'b0;
            frame_user   <= 1'b0;
            underrun_cnt <= 8'd0;
        end else if (load_edge) begin
            slot_cnt <= '0;
            if (!frame_user && underrun_cnt != 8'hFF) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
            if (hold_full) begin
                shift_reg  <= hold_reg;
                hold_full  <= 1'b0;
                frame_user <= 1'b1;
            end else if (bus.din_valid) begin
                shift_reg  <= bus.din;     // bypass: hold stays empty
                frame_user <= 1'b1;
            end else begin
                shift_reg  <= IDLE_WORD;
                frame_user <= 1'b0;
            end
        end else begin
            slot_cnt  <= slot_cnt + 1'b1;
            shift_reg <= shift_reg << 1;
            if (accept) begin
                hold_full <= 1'b1;
            end
        end
    end

    // Holding register data; only meaningful while hold_full is set.
    always_ff @(posedge clock_in) begin
        // NOTE: pure data storage is left unreset; hold_full alone says whether it holds a word.
        if (!load_edge && accept) begin
            hold_reg <= bus.din;
        end
    end

endmodule
